// File: rtl/xm_shift_pkg.sv
// Shared types for the X-Makina shift datapath.
// The sequencer and the single-bit shifter_unit both use them.
package xm_shift_pkg;

    typedef enum logic {
        SH_SRA = 1'b0,
        SH_RRC = 1'b1
    } sh_op_t;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_SHIFT,
        SQ_DONE
    } sq_state_t;

endpackage

// File: rtl/shifter_unit.sv
// Single-bit shifter: one arithmetic shift right (SRA) or one rotate right through carry (RRC).
// The bit shifted out of the LSB becomes cout.
module shifter_unit
    import xm_shift_pkg::*;
#(
    parameter int WORD = 16
) (
    input  logic            op,
    input  logic            cin,
    input  logic [WORD-1:0] src,
    output logic [WORD-1:0] res,
    output logic            cout
);

    always_comb begin
        res  = {(op == SH_RRC) ? cin : src[WORD-1], src[WORD-1:1]};
        cout = src[0];
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle n-bit SRA/RRC controller. It iterates shifter_unit once per clock
// and presents the final word, carry and Z/N flags with a start/done handshake.
module shift_sequencer
    import xm_shift_pkg::*;
#(
    parameter int WORD        = 16,
    parameter int CNT_W       = 4,
    parameter bit EXT_SHIFTER = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [CNT_W-1:0] count,
    input  logic [WORD-1:0]  src,
    input  logic             cin,
    output logic             sh_op,
    output logic             sh_cin,
    output logic [WORD-1:0]  sh_src,
    input  logic [WORD-1:0]  sh_res,
    input  logic             sh_cout,
    output logic             busy,
    output logic             done,
    output logic [WORD-1:0]  res,
    output logic             cout,
    output logic             z,
    output logic             n
);

    sq_state_t        state_q, state_d;
    logic [WORD-1:0]  data_q, data_d;
    logic             carry_q, carry_d;
    sh_op_t           op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WORD-1:0]  res_q, res_d;
    logic             cout_q, cout_d;
    logic             z_q, z_d;
    logic             n_q, n_d;

    logic [WORD-1:0]  int_res;
    logic             int_cout;
    logic [WORD-1:0]  step_res;
    logic             step_cout;

    assign sh_src = data_q;
    assign sh_cin = carry_q;
    assign sh_op  = op_q;

    shifter_unit #(
        .WORD(WORD)
    ) u_shifter (
        .op   (op_q),
        .cin  (carry_q),
        .src  (data_q),
        .res  (int_res),
        .cout (int_cout)
    );

    // A split datapath feeds the step result back through sh_res/sh_cout instead.
    assign step_res  = EXT_SHIFTER ? sh_res  : int_res;
    assign step_cout = EXT_SHIFTER ? sh_cout : int_cout;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        res_d   = res_q;
        cout_d  = cout_q;
        z_d     = z_q;
        n_d     = n_q;
        case (state_q)
            SQ_IDLE: begin
                if (start) begin
                    data_d  = src;
                    carry_d = cin;
                    if (count != '0) begin
                        op_d    = sh_op_t'(op);
                        cnt_d   = count;
                        state_d = SQ_SHIFT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = SQ_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            SQ_SHIFT: begin
                data_d  = step_res;
                carry_d = step_cout;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SQ_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            SQ_DONE: begin
                res_d   = data_q;
                cout_d  = carry_q;
                z_d     = (data_q == '0);
                n_d     = data_q[WORD-1];
                state_d = SQ_IDLE;
            end
            default: state_d = SQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SQ_IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            op_q    <= SH_SRA;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    // During DONE the result registers are not loaded yet, so consumers see data_q directly.
    always_comb begin
        busy = busy_q;
        done = done_q;
        if (state_q == SQ_DONE) begin
            res  = data_q;
            cout = carry_q;
            z    = (data_q == '0);
            n    = data_q[WORD-1];
        end else begin
            res  = res_q;
            cout = cout_q;
            z    = z_q;
            n    = n_q;
        end
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sits around the single-bit shifter_unit and runs n-bit SRA/RRC operations for the X-Makina execute stage.
- Loads the operand, drives shifter_unit once per clock, and feeds its res/cout back as the next iteration's src/cin.
- Presents the final word, carry and Z/N flags to the PSW/writeback logic with a start/done handshake.

Parameters:
WORD, 16, datapath width; must match shifter_unit WORD
CNT_W, 4, width of shift-count field; maximum count is 2^CNT_W-1

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
op  in  1  0 = SRA, 1 = RRC; same encoding as shifter_unit
count  in  CNT_W  number of single-bit steps
src  in  WORD  operand
cin  in  1  PSW carry in; used by RRC
sh_op  out  1  to shifter_unit op
sh_cin  out  1  to shifter_unit cin
sh_src  out  WORD  to shifter_unit src
sh_res  in  WORD  from shifter_unit res
sh_cout  in  1  from shifter_unit cout
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse; result valid
res  out  WORD  final shifted word
cout  out  1  final carry
z  out  1  res == 0
n  out  1  res[WORD-1]

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy=0, done=0, res=0, cout=0, z=0, n=0.
  - Internal data register, carry register and counter cleared.
  - Takes effect immediately, including mid-operation; the partial result is discarded and no done pulse is issued.
- Registers:
  - data_q (WORD), carry_q (1), op_q (1), cnt_q (CNT_W).
  - sh_src=data_q, sh_cin=carry_q, sh_op=op_q, all driven combinationally.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, start=1, count!=0: load data_q=src, carry_q=cin, op_q=op, cnt_q=count; go to SHIFT; busy=1 next cycle.
  - IDLE, start=1, count==0: load data_q=src, carry_q=cin; go to DONE directly. Result is src unchanged; cout=cin.
  - IDLE, start=0: hold. Outputs res/cout/z/n keep the last result.
  - SHIFT, each cycle: data_q<=sh_res, carry_q<=sh_cout, cnt_q<=cnt_q-1. When cnt_q==1, go to DONE.
  - DONE, one cycle:
    - done=1, busy=0.
    - res<=data_q, cout<=carry_q, z<=(data_q==0), n<=data_q[WORD-1]. These are registered, so they are visible the cycle after done. Consumers sample on the done cycle via a combinational view: res/cout/z/n are driven from data_q/carry_q while in DONE and from the output registers otherwise.
    - Return to IDLE.
- Latency: start accepted at edge k; done is high during cycle k+count+1. count=0 gives done at k+1.
- RRC carry chaining: each step rotates the previous step's cout into the MSB (sh_cin=carry_q). This makes n-step RRC equal a (WORD+1)-bit rotate through carry.
- SRA: cin is ignored for the data result. The final cout is the last bit shifted out.
- start while busy or in DONE: ignored, with no queuing. op/count/src are only sampled at acceptance.
- Count wrap: cnt_q never decrements below 1 in SHIFT; there is no underflow path.
- count > WORD (e.g. 15 with WORD=8 builds) is legal: SRA saturates to all sign bits, RRC keeps rotating.

Decomposition:
- Shared package xm_shift_pkg:
  - typedef enum logic {SH_SRA=1'b0, SH_RRC=1'b1} sh_op_t; to be reused by shifter_unit.
  - typedef enum logic [1:0] {SQ_IDLE, SQ_SHIFT, SQ_DONE} sq_state_t.
- One sub-module is natural: instantiate shifter_unit internally as u_shifter, with the sh_* ports exposed only in the top-level variant. The default build instantiates it and ties sh_* internally; the sh_* ports are kept for the split datapath.

Test Plan:
- SRA: src=0x8004, count=2, start pulse -> done 3 cycles later; res=0xE001, cout=0, n=1, z=0; busy high for exactly 2 cycles.
- RRC: cin=0, src=0x0003, count=2 -> intermediate 0x0001/c=1; final res=0x8000, cout=1, n=1, z=0.
- Zero count: op=RRC, cin=1, src=0x1234, count=0 -> done next cycle; res=0x1234, cout=1, busy never asserted.
- Max count: SRA, src=0x4000, count=15 -> done at k+16; res=0x0000, cout=1, z=1, n=0.
- Start while busy: second start (src=0xFFFF) during SHIFT of first op (0x8004, SRA, 2) -> ignored; result 0xE001, only one done pulse.
- Reset mid-op: assert rst asynchronously during SHIFT cycle 1 of a count=8 op -> busy, done, res, cout, z and n read 0 immediately; after release, no done pulse until a new start.
